uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter (8N1) fed by a byte FIFO.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   DEPTH    = (PW+1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif
   logic          push, pop, bit_end;

   assign in_ready   = (count_q < DEPTH);
   assign push       = in_valid && in_ready;
   assign bit_end    = (timer_q == BIT_LAST);
   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);
   assign fifo_count = count_q;

   // tx_d always carries the level of the state being entered, so tx is a plain flop.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop      = 1'b1;
               shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
               parity_d = ^mem_q[rd_ptr_q];
`endif
               state_d  = S_START;
               timer_d  = '0;
               tx_d     = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               timer_d = '0;
               idx_d   = 3'd0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               timer_d = '0;
               tx_d    = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               timer_d = '0;
               tx_d    = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         idx_q    <= 3'd0;
         shift_q  <= 8'h00;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule
